// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate L1 data cache.
// Wishbone slave toward the CPU (one 128-bit line per access) and a
// wishbone master toward L2 for line fills and dirty evictions.
module dcache_wb #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [11:0]  cpu_adr,
  input  logic [127:0] cpu_dat_m,
  input  logic [15:0]  cpu_sel,
  input  logic         cpu_we,
  input  logic         cpu_stb,
  input  logic         cpu_cyc,
  output logic [127:0] cpu_dat_s,
  output logic         cpu_ack,
  output logic [11:0]  mem_adr,
  output logic [127:0] mem_dat_m,
  output logic [15:0]  mem_sel,
  output logic         mem_we,
  output logic         mem_stb,
  output logic         mem_cyc,
  input  logic [127:0] mem_dat_s,
  input  logic         mem_ack,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESPOND   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t state;

  // Per-set bookkeeping; only valid/dirty carry a reset.
  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [127:0]        line_mem [NUM_SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             req;
  logic             hit;
  logic [127:0]     cur_line;
  logic [127:0]     merged_line;
  logic             line_we;
  logic             tag_we;
  logic [127:0]     line_wdata;

  // Byte-granular merge of CPU write data into a stored line.
  function automatic logic [127:0] merge_bytes(input logic [127:0] old_line,
                                               input logic [127:0] new_data,
                                               input logic [15:0]  sel);
    logic [127:0] res;
    res = old_line;
    for (int i = 0; i < 16; i++) begin
      if (sel[i]) begin
        res[8*i +: 8] = new_data[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_line[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign idx = cpu_adr[IDX_W-1:0];
  assign tag = cpu_adr[11:IDX_W];

  // Lookup of the addressed set: request qualification, hit detect, merged write line.
  always_comb begin
    req         = cpu_stb & cpu_cyc;
    cur_line    = line_mem[idx];
    hit         = valid[idx] & (tag_mem[idx] == tag);
    merged_line = merge_bytes(cur_line, cpu_dat_m, cpu_sel);
  end

  // Storage write strobes: CPU write hit in IDLE, or line fill completing in ALLOCATE.
  always_comb begin
    line_we    = 1'b0;
    tag_we     = 1'b0;
    line_wdata = merged_line;
    if (state == IDLE && req && hit && cpu_we) begin
      line_we    = 1'b1;
      tag_we     = 1'b0;
      line_wdata = merged_line;
    end else if (state == ALLOCATE && mem_ack) begin
      line_we    = 1'b1;
      tag_we     = 1'b1;
      line_wdata = mem_dat_s;
    end else begin
      line_we    = 1'b0;
      tag_we     = 1'b0;
      line_wdata = merged_line;
    end
  end

  // Tag and data arrays: plain RAM-style storage without reset.
  always_ff @(posedge clk) begin
    if (line_we) begin
      line_mem[idx] <= line_wdata;
    end
    if (tag_we) begin
      tag_mem[idx] <= tag;
    end
  end

  // Control FSM with registered CPU/L2 outputs, valid/dirty bits and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      cpu_dat_s  <= 128'd0;
      cpu_ack    <= 1'b0;
      mem_adr    <= 12'd0;
      mem_dat_m  <= 128'd0;
      mem_sel    <= 16'd0;
      mem_we     <= 1'b0;
      mem_stb    <= 1'b0;
      mem_cyc    <= 1'b0;
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              hit_count <= hit_count + 16'd1;
              if (cpu_we) begin
                if (cpu_sel != 16'd0) begin
                  dirty[idx] <= 1'b1;
                end
              end else begin
                cpu_dat_s <= cur_line;
              end
              cpu_ack <= 1'b1;
              state   <= RESPOND;
            end else begin
              miss_count <= miss_count + 16'd1;
              mem_stb    <= 1'b1;
              mem_cyc    <= 1'b1;
              mem_sel    <= 16'hFFFF;
              if (valid[idx] && dirty[idx]) begin
                // Evict the resident dirty line before fetching the new one.
                mem_we    <= 1'b1;
                mem_adr   <= {tag_mem[idx], idx};
                mem_dat_m <= cur_line;
                state     <= WRITEBACK;
              end else begin
                mem_we  <= 1'b0;
                mem_adr <= cpu_adr;
                state   <= ALLOCATE;
              end
            end
          end
        end
        RESPOND: begin
          // The request is still held this cycle; it is deliberately not looked at.
          state <= IDLE;
        end
        WRITEBACK: begin
          if (mem_ack) begin
            dirty[idx] <= 1'b0;
            mem_we     <= 1'b0;
            mem_adr    <= cpu_adr;
            mem_dat_m  <= 128'd0;
            state      <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_ack) begin
            // Fill lands in the arrays this edge; IDLE then re-checks and hits.
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            mem_stb    <= 1'b0;
            mem_cyc    <= 1'b0;
            mem_sel    <= 16'd0;
            mem_adr    <= 12'd0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: scoreboard bench for dcache_wb. Stimulus pushes expected CPU
// responses and expected L2 transactions into queues; monitors pop and compare.
module tb_dcache_wb;

  logic         clk;
  logic         rst_n;
  logic [11:0]  cpu_adr;
  logic [127:0] cpu_dat_m;
  logic [15:0]  cpu_sel;
  logic         cpu_we;
  logic         cpu_stb;
  logic         cpu_cyc;
  logic [127:0] cpu_dat_s;
  logic         cpu_ack;
  logic [11:0]  mem_adr;
  logic [127:0] mem_dat_m;
  logic [15:0]  mem_sel;
  logic         mem_we;
  logic         mem_stb;
  logic         mem_cyc;
  logic [127:0] mem_dat_s;
  logic         mem_ack;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  dcache_wb #(.NUM_SETS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_adr(cpu_adr), .cpu_dat_m(cpu_dat_m), .cpu_sel(cpu_sel), .cpu_we(cpu_we),
    .cpu_stb(cpu_stb), .cpu_cyc(cpu_cyc), .cpu_dat_s(cpu_dat_s), .cpu_ack(cpu_ack),
    .mem_adr(mem_adr), .mem_dat_m(mem_dat_m), .mem_sel(mem_sel), .mem_we(mem_we),
    .mem_stb(mem_stb), .mem_cyc(mem_cyc), .mem_dat_s(mem_dat_s), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           chk;
    logic [127:0] dat;
  } cpu_exp_t;

  typedef struct {
    logic [11:0]  adr;
    logic         we;
    logic [127:0] dat;
  } mem_exp_t;

  cpu_exp_t     cpu_q[$];
  mem_exp_t     mem_q[$];
  logic [127:0] l2_mem [logic [11:0]];
  int           l2_lat;
  int           l2_cnt;
  int           checks;
  int           failures;
  logic [15:0]  exp_hit;
  logic [15:0]  exp_miss;
  logic         prev_ack;

  localparam logic [127:0] A5_LINE = {16{8'hA5}};
  localparam logic [127:0] C3_LINE = {16{8'h3C}};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  function automatic logic [127:0] l2_read(input logic [11:0] adr);
    if (l2_mem.exists(adr)) begin
      return l2_mem[adr];
    end else begin
      return C3_LINE;
    end
  endfunction

  // L2 responder and L2-side monitor: ack each strobed cycle after l2_lat cycles.
  initial begin
    mem_ack   = 1'b0;
    mem_dat_s = 128'd0;
    l2_cnt    = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst_n && mem_stb && mem_cyc) begin
        if (l2_cnt >= l2_lat - 1) begin
          if (mem_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL l2_unexpected: got adr=%h we=%b expected no L2 cycle", mem_adr, mem_we);
          end else begin
            mem_exp_t e;
            e = mem_q.pop_front();
            check("l2_adr", {116'd0, mem_adr}, {116'd0, e.adr});
            check("l2_we", {127'd0, mem_we}, {127'd0, e.we});
            check("l2_sel", {112'd0, mem_sel}, {112'd0, 16'hFFFF});
            if (e.we) begin
              check("l2_wdata", mem_dat_m, e.dat);
            end
          end
          if (mem_we) begin
            l2_mem[mem_adr] = mem_dat_m;
          end else begin
            mem_dat_s = l2_read(mem_adr);
          end
          mem_ack = 1'b1;
          l2_cnt  = 0;
        end else begin
          l2_cnt++;
        end
      end else begin
        l2_cnt = 0;
      end
    end
  end

  // CPU-side monitor: every ack pops one expectation; ack must be a single-cycle pulse.
  initial begin
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_ack) begin
        check("ack_pulse", {127'd0, prev_ack}, 128'd0);
        if (cpu_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cpu_unexpected_ack: got ack expected none");
        end else begin
          cpu_exp_t e;
          e = cpu_q.pop_front();
          if (e.chk) begin
            check("cpu_rdata", cpu_dat_s, e.dat);
          end
        end
      end
      prev_ack = cpu_ack;
    end
  end

  task automatic do_req(input string name, input logic [11:0] adr, input logic we,
                        input logic [127:0] dat, input logic [15:0] sel,
                        input logic [127:0] exp_dat, input int exp_lat);
    int cyc_n;
    bit got;
    cpu_q.push_back('{!we, exp_dat});
    @(posedge clk);
    #1;
    cpu_adr   = adr;
    cpu_we    = we;
    cpu_dat_m = dat;
    cpu_sel   = sel;
    cpu_stb   = 1'b1;
    cpu_cyc   = 1'b1;
    cyc_n     = 0;
    got       = 1'b0;
    while (!got && cyc_n < 200) begin
      @(negedge clk);
      cyc_n++;
      if (cpu_ack) got = 1'b1;
    end
    cpu_stb = 1'b0;
    cpu_cyc = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no ack expected ack within 200 cycles", name);
      void'(cpu_q.pop_back());
    end else begin
      check({name, "_latency"}, cyc_n, exp_lat);
      check({name, "_hits"}, {112'd0, hit_count}, {112'd0, exp_hit});
      check({name, "_misses"}, {112'd0, miss_count}, {112'd0, exp_miss});
    end
  endtask

  initial begin
    logic [127:0] beef_line;
    logic [127:0] wdat;
    logic [127:0] part_line;
    int           acks;
    int           stbs;
    int           n;

    checks    = 0;
    failures  = 0;
    l2_lat    = 3;
    exp_hit   = 16'd0;
    exp_miss  = 16'd0;
    l2_mem[12'h010] = A5_LINE;
    beef_line = {{14{8'hA5}}, 16'hBEEF};
    wdat      = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    part_line = {{8{8'h3C}}, 32'hFEDC_BA98, 32'h3C3C_3C3C};
    cpu_adr = 12'd0; cpu_dat_m = 128'd0; cpu_sel = 16'd0;
    cpu_we = 1'b0; cpu_stb = 1'b0; cpu_cyc = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", {127'd0, cpu_ack}, 128'd0);
    check("rst_rdata", cpu_dat_s, 128'd0);
    check("rst_mem_stb", {126'd0, mem_stb, mem_cyc}, 128'd0);
    check("rst_counts", {96'd0, hit_count, miss_count}, 128'd0);
    rst_n = 1'b1;

    // Clean miss, fill from L2, then hit; 1 + 3 + 2 cycles.
    exp_miss++; exp_hit++;
    mem_q.push_back('{12'h010, 1'b0, 128'd0});
    do_req("rd_miss", 12'h010, 1'b0, 128'd0, 16'd0, A5_LINE, 6);
    exp_hit++;
    do_req("rd_hit", 12'h010, 1'b0, 128'd0, 16'd0, A5_LINE, 2);
    exp_hit++;
    do_req("wr_hit", 12'h010, 1'b1, {{14{8'h77}}, 16'hBEEF}, 16'h0003, 128'd0, 2);
    exp_hit++;
    do_req("rd_merged", 12'h010, 1'b0, 128'd0, 16'd0, beef_line, 2);

    // Conflict miss on dirty set 0: writeback of 0x010, then fill of 0x110.
    exp_miss++; exp_hit++;
    mem_q.push_back('{12'h010, 1'b1, beef_line});
    mem_q.push_back('{12'h110, 1'b0, 128'd0});
    do_req("rd_evict", 12'h110, 1'b0, 128'd0, 16'd0, C3_LINE, 9);

    // Evicted data round-trips through L2; set 0 was clean so no writeback.
    exp_miss++; exp_hit++;
    mem_q.push_back('{12'h010, 1'b0, 128'd0});
    do_req("rd_refill", 12'h010, 1'b0, 128'd0, 16'd0, beef_line, 6);

    // Write miss allocates, then merges bytes 7:4.
    exp_miss++; exp_hit++;
    mem_q.push_back('{12'h021, 1'b0, 128'd0});
    do_req("wr_miss", 12'h021, 1'b1, wdat, 16'h00F0, 128'd0, 6);
    exp_hit++;
    do_req("rd_part", 12'h021, 1'b0, 128'd0, 16'd0, part_line, 2);

    // Write hit with no byte enables must leave the set clean.
    exp_hit++;
    do_req("wr_sel0", 12'h010, 1'b1, wdat, 16'h0000, 128'd0, 2);
    exp_miss++; exp_hit++;
    mem_q.push_back('{12'h110, 1'b0, 128'd0});
    do_req("rd_clean_evict", 12'h110, 1'b0, 128'd0, 16'd0, C3_LINE, 6);

    // stb without cyc, and cyc without stb, are both ignored.
    acks = 0; stbs = 0;
    @(posedge clk); #1;
    cpu_adr = 12'h110; cpu_we = 1'b0; cpu_stb = 1'b1; cpu_cyc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        cpu_stb = 1'b0;
        cpu_cyc = 1'b1;
      end
      @(negedge clk);
      if (cpu_ack) acks++;
      if (mem_stb) stbs++;
    end
    cpu_stb = 1'b0; cpu_cyc = 1'b0;
    check("half_req_acks", acks, 0);
    check("half_req_mem", stbs, 0);
    check("half_req_hits", {112'd0, hit_count}, {112'd0, exp_hit});

    // Asynchronous reset in the middle of a long fill.
    l2_lat = 20;
    @(posedge clk); #1;
    cpu_adr = 12'h023; cpu_we = 1'b0; cpu_sel = 16'd0; cpu_stb = 1'b1; cpu_cyc = 1'b1;
    n = 0;
    while (!mem_stb && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("fill_stb", {127'd0, mem_stb}, 128'd1);
    check("fill_adr", {116'd0, mem_adr}, {116'd0, 12'h023});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_fill_stb", {126'd0, mem_stb, mem_cyc}, 128'd0);
    check("rst_fill_counts", {96'd0, hit_count, miss_count}, 128'd0);
    check("rst_fill_rdata", cpu_dat_s, 128'd0);
    cpu_stb = 1'b0; cpu_cyc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    l2_lat   = 3;
    exp_hit  = 16'd0;
    exp_miss = 16'd0;

    // Cache contents were invalidated: previously resident line misses again.
    exp_miss++; exp_hit++;
    mem_q.push_back('{12'h010, 1'b0, 128'd0});
    do_req("rd_after_rst", 12'h010, 1'b0, 128'd0, 16'd0, beef_line, 6);

    // Hit counter wrap: park the counter at its maximum, then take one hit.
    @(negedge clk);
    force dut.hit_count = 16'hFFFF;
    @(negedge clk);
    release dut.hit_count;
    exp_hit = 16'hFFFF;
    exp_hit++;
    do_req("hit_wrap", 12'h010, 1'b0, 128'd0, 16'd0, beef_line, 2);

    repeat (5) @(negedge clk);
    check("cpu_q_empty", cpu_q.size(), 0);
    check("mem_q_empty", mem_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
